mul_stall_controller: RTL and testbench

- Sequences a radix-2 iterative shift-add multiplier for the MUL instruction in the EX stage.
- Stalls the pipeline (PC, IF/ID, ID/EX) while the multiply runs.
- Presents the low DATA_WIDTH product bits and the destination register for one cycle so EX/MEM can capture them.
- Sits beside the ALU; the EX-stage control asserts start_i whenever the instruction in EX is MUL.

---
 rtl/mul_stall_controller.sv | 106 ++++++++++
 tb/tb_mul_stall_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_stall_controller.sv
// rtl/mul_stall_controller.sv - EX-stage sequencer for a radix-2 shift-add MUL with pipeline stall
// One partial product per cycle; result and destination are presented for a single DONE cycle.
module mul_stall_controller #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] src1_i,
   input  logic [DATA_WIDTH-1:0] src2_i,
   input  logic [4:0]            rd_i,
   output logic                  stall_o,
   output logic                  busy_o,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic [4:0]            rd_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

   state_t                state_q;
   logic [DATA_WIDTH-1:0] mcand_q;
   logic [DATA_WIDTH-1:0] mplier_q;
   logic [DATA_WIDTH-1:0] acc_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [4:0]            rd_q;

   logic [DATA_WIDTH-1:0] addend_d;
   logic [DATA_WIDTH-1:0] acc_d;
   logic [CNT_WIDTH-1:0]  cnt_d;

   assign addend_d = mplier_q[0] ? mcand_q : '0;
   assign acc_d    = acc_q + addend_d;
   assign cnt_d    = cnt_q + 1'b1;

   // Flush wins over everything except reset; start is only honoured in IDLE.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         rd_q     <= '0;
      end else if (flush_i) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  mcand_q  <= src1_i;
                  mplier_q <= src2_i;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  rd_q     <= rd_i;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_d;
               if (cnt_q == LAST_CNT) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Stall must act in the same cycle the MUL sits in EX, so these decode the current state.
   always_comb begin
      stall_o  = 1'b0;
      busy_o   = 1'b0;
      valid_o  = 1'b0;
      result_o = '0;
      rd_o     = '0;
      if (rst_n) begin
         busy_o   = (state_q != IDLE);
         result_o = acc_q;
         rd_o     = rd_q;
         case (state_q)
            IDLE:    stall_o = start_i & ~flush_i;
            RUN:     stall_o = ~flush_i;
            DONE:    valid_o = ~flush_i;
            default: stall_o = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_stall_controller.sv
// tb/tb_mul_stall_controller.sv - self-checking bench for mul_stall_controller
// Directed scenarios plus a randomized run against a cycle-count reference model.
module tb_mul_stall_controller;

   localparam int DW = 32;

   logic          clk_i   = 1'b0;
   logic          rst_n   = 1'b0;
   logic          start_i = 1'b0;
   logic          flush_i = 1'b0;
   logic [DW-1:0] src1_i  = '0;
   logic [DW-1:0] src2_i  = '0;
   logic [4:0]    rd_i    = '0;
   logic          stall_o;
   logic          busy_o;
   logic          valid_o;
   logic [DW-1:0] result_o;
   logic [4:0]    rd_o;

   int checks = 0;
   int errors = 0;

   mul_stall_controller #(.DATA_WIDTH(DW), .CNT_WIDTH(5)) dut (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .start_i (start_i),
      .flush_i (flush_i),
      .src1_i  (src1_i),
      .src2_i  (src2_i),
      .rd_i    (rd_i),
      .stall_o (stall_o),
      .busy_o  (busy_o),
      .valid_o (valid_o),
      .result_o(result_o),
      .rd_o    (rd_o)
   );

   always #5 clk_i = ~clk_i;

   // One cycle: inputs change just after the rising edge, outputs are observed at the falling edge.
   task automatic drive(input logic r, input logic s, input logic f,
                        input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [4:0] d);
      @(posedge clk_i);
      #1;
      rst_n   = r;
      start_i = s;
      flush_i = f;
      src1_i  = a;
      src2_i  = b;
      rd_i    = d;
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'($urandom), $urandom, $urandom, 5'($urandom));
         checks++;
         if ({stall_o, busy_o, valid_o, result_o, rd_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got stall=%b busy=%b valid=%b result=%h rd=%0d exp all zero",
                     stall_o, busy_o, valid_o, result_o, rd_o);
         end
      end
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      checks++;
      if ({stall_o, busy_o, valid_o, result_o, rd_o} !== '0) begin
         errors++;
         $display("FAIL idle_after_reset got stall=%b busy=%b valid=%b result=%h rd=%0d exp all zero",
                  stall_o, busy_o, valid_o, result_o, rd_o);
      end
      drive(1'b1, 1'b1, 1'b1, 32'd7, 32'd6, 5'd5);
      checks++;
      if (stall_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_flush_over_start_stall got %b exp 0", stall_o);
      end
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_flush_no_launch busy got %b exp 0", busy_o);
      end
   endtask

   task automatic test_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [4:0] d);
      logic [DW-1:0] exp_res;
      int stalls = 0;
      int vcyc   = 0;
      bit seen   = 0;
      exp_res = a * b;
      for (int i = 1; i <= DW + 8 && !seen; i++) begin
         if (i == 1) drive(1'b1, 1'b1, 1'b0, a, b, d);
         else        drive(1'b1, 1'b1, 1'b0, $urandom, $urandom, 5'($urandom));
         if (valid_o === 1'b1) begin
            seen = 1;
            vcyc = i;
            checks++;
            if (result_o !== exp_res || rd_o !== d || stall_o !== 1'b0) begin
               errors++;
               $display("FAIL mul_result %h*%h got result=%h rd=%0d stall=%b exp result=%h rd=%0d stall=0",
                        a, b, result_o, rd_o, stall_o, exp_res, d);
            end
         end else if (stall_o === 1'b1) begin
            stalls++;
         end
      end
      checks++;
      if (!seen || vcyc != DW + 2) begin
         errors++;
         $display("FAIL mul_latency got valid cycle %0d (seen=%0d) exp %0d", vcyc, seen, DW + 2);
      end
      checks++;
      if (stalls != DW + 1) begin
         errors++;
         $display("FAIL mul_stall_count got %0d exp %0d", stalls, DW + 1);
      end
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      checks++;
      if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL mul_after_done got valid=%b busy=%b exp 0 0", valid_o, busy_o);
      end
   endtask

   task automatic test_back_to_back();
      int nval = 0;
      int v1 = 0;
      int v2 = 0;
      for (int i = 1; i <= 2 * (DW + 2) + 10; i++) begin
         if (nval == 0)      drive(1'b1, 1'b1, 1'b0, 32'd7, 32'd6, 5'd5);
         else if (nval == 1) drive(1'b1, 1'b1, 1'b0, 32'd3, 32'd3, 5'd9);
         else                drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
         if (valid_o === 1'b1) begin
            nval++;
            if (nval == 1) v1 = i;
            if (nval == 2) v2 = i;
            checks++;
            if ((nval == 1 && (result_o !== 32'd42 || rd_o !== 5'd5)) ||
                (nval == 2 && (result_o !== 32'd9 || rd_o !== 5'd9)) || nval > 2) begin
               errors++;
               $display("FAIL b2b_result pulse %0d got result=%0d rd=%0d exp %0d/%0d",
                        nval, result_o, rd_o, (nval == 1) ? 42 : 9, (nval == 1) ? 5 : 9);
            end
         end
      end
      checks++;
      if (nval != 2 || v2 - v1 != DW + 2) begin
         errors++;
         $display("FAIL b2b_spacing got pulses=%0d spacing=%0d exp 2 and %0d", nval, v2 - v1, DW + 2);
      end
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_third busy got %b exp 0", busy_o);
      end
   endtask

   task automatic test_flush();
      int nval = 0;
      for (int i = 1; i <= 10; i++) drive(1'b1, 1'b1, 1'b0, 32'd7, 32'd6, 5'd5);
      drive(1'b1, 1'b1, 1'b1, 32'd7, 32'd6, 5'd5);
      checks++;
      if (stall_o !== 1'b0 || valid_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL flush_cycle got stall=%b valid=%b busy=%b exp 0 0 1", stall_o, valid_o, busy_o);
      end
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      checks++;
      if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_to_idle got busy=%b stall=%b exp 0 0", busy_o, stall_o);
      end
      for (int i = 0; i < DW + 4; i++) begin
         drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
         if (valid_o === 1'b1) nval++;
      end
      checks++;
      if (nval != 0) begin
         errors++;
         $display("FAIL flush_no_valid got %0d pulses exp 0", nval);
      end
   endtask

   task automatic test_reset_mid();
      int nval = 0;
      for (int i = 1; i <= 15; i++) drive(1'b1, 1'b1, 1'b0, 32'd7, 32'd6, 5'd5);
      drive(1'b0, 1'b1, 1'b0, 32'd7, 32'd6, 5'd5);
      checks++;
      if ({stall_o, busy_o, valid_o, result_o, rd_o} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got stall=%b busy=%b valid=%b result=%h rd=%0d exp all zero",
                  stall_o, busy_o, valid_o, result_o, rd_o);
      end
      drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      checks++;
      if ({stall_o, busy_o, valid_o, result_o, rd_o} !== '0) begin
         errors++;
         $display("FAIL midreset_idle got stall=%b busy=%b valid=%b result=%h rd=%0d exp all zero",
                  stall_o, busy_o, valid_o, result_o, rd_o);
      end
      for (int i = 0; i < DW + 4; i++) begin
         drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
         if (valid_o === 1'b1) nval++;
      end
      checks++;
      if (nval != 0) begin
         errors++;
         $display("FAIL midreset_no_valid got %0d pulses exp 0", nval);
      end
   endtask

   // Reference: m_age counts cycles since acceptance (0 = idle, 1..DW = iterating, DW+1 = result cycle).
   task automatic test_random(input int ncycles);
      int            m_age = 0;
      logic [DW-1:0] m_prod = '0;
      logic [4:0]    m_rd = '0;
      int            done_cnt = 0;
      for (int n = 0; n < ncycles; n++) begin
         logic          r, s, f, e_stall, e_busy, e_valid;
         logic [DW-1:0] a, b;
         logic [4:0]    d;
         r = ($urandom_range(0, 299) != 0);
         s = ($urandom_range(0, 3) != 0);
         f = ($urandom_range(0, 89) == 0);
         a = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 255)) : $urandom;
         b = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 255)) : $urandom;
         d = 5'($urandom);
         drive(r, s, f, a, b, d);
         e_stall = 1'b0;
         e_busy  = 1'b0;
         e_valid = 1'b0;
         if (r) begin
            e_busy = (m_age != 0);
            if (m_age == 0)        e_stall = s & ~f;
            else if (m_age <= DW)  e_stall = ~f;
            else                   e_valid = ~f;
         end
         checks++;
         if (stall_o !== e_stall || busy_o !== e_busy || valid_o !== e_valid) begin
            errors++;
            $display("FAIL rand_ctrl cycle %0d got stall=%b busy=%b valid=%b exp %b %b %b",
                     n, stall_o, busy_o, valid_o, e_stall, e_busy, e_valid);
         end
         if (e_valid) begin
            done_cnt++;
            checks++;
            if (result_o !== m_prod || rd_o !== m_rd) begin
               errors++;
               $display("FAIL rand_result cycle %0d got result=%h rd=%0d exp %h %0d",
                        n, result_o, rd_o, m_prod, m_rd);
            end
         end
         if (!r) begin
            checks++;
            if (result_o !== '0 || rd_o !== '0) begin
               errors++;
               $display("FAIL rand_reset_data cycle %0d got result=%h rd=%0d exp 0 0", n, result_o, rd_o);
            end
         end
         if (!r || f)          m_age = 0;
         else if (m_age == 0) begin
            if (s) begin
               m_age  = 1;
               m_prod = a * b;
               m_rd   = d;
            end
         end else if (m_age <= DW) m_age++;
         else                       m_age = 0;
      end
      checks++;
      if (done_cnt == 0) begin
         errors++;
         $display("FAIL rand_coverage got %0d completed products exp nonzero", done_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_mul(32'd7, 32'd6, 5'd5);
      test_mul(32'hFFFF_FFFD, 32'd4, 5'd12);
      test_mul(32'h0001_0000, 32'h0001_0000, 5'd31);
      test_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
      test_back_to_back();
      test_flush();
      test_mul(32'd2, 32'd5, 5'd3);
      test_reset_mid();
      test_mul(32'd7, 32'd6, 5'd5);
      test_random(2000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
